rv_imm_enc: RTL

Streaming instruction encoder, the inverse of immediate generation. Accepts an encode request (instruction kind, register fields, funct3, 64-bit immediate) and emits one or two 32-bit RV64 instruction words on a valid/ready stream. It range-checks and packs the immediate into I/S/B/U layouts. For kind LI it expands an arbitrary signed-32 constant into an ADDI, LUI, or LUI+ADDIW sequence. Used by the self-test/program-buffer generator to synthesise instruction streams for the core.

---
 rtl/rv_imm_enc.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/rv_imm_enc.sv
// RV64 instruction encoder: range-checks and packs an immediate into
// I/S/B/U layouts, expands LI into ADDI / LUI / LUI+ADDIW, and streams
// the resulting words out on a valid/ready interface.
module rv_imm_enc #(
  parameter int XLEN = 64
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_kind_i,
  input  logic [4:0]       req_rd_i,
  input  logic [4:0]       req_rs1_i,
  input  logic [4:0]       req_rs2_i,
  input  logic [2:0]       req_funct3_i,
  input  logic [XLEN-1:0]  req_imm_i,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic [31:0]      instr_o,
  output logic             instr_last_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic             busy_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EMIT1 = 2'd1;
  localparam logic [1:0] S_EMIT2 = 2'd2;

  localparam logic [2:0] K_LOAD   = 3'd0;
  localparam logic [2:0] K_STORE  = 3'd1;
  localparam logic [2:0] K_BRANCH = 3'd2;
  localparam logic [2:0] K_LUI    = 3'd3;
  localparam logic [2:0] K_AUIPC  = 3'd4;
  localparam logic [2:0] K_LI     = 3'd5;
  localparam logic [2:0] K_ADDI   = 3'd6;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_ADDIW  = 7'b0011011;

  logic [1:0]  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        last_q, last_d;
  logic [31:0] word2_q, word2_d;
  logic        has2_q, has2_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;

  // Request-side decode results
  logic        accept;
  logic        fit12, fit13, fit32;
  logic [31:0] hi_sum;
  logic [11:0] lo;
  logic [1:0]  req_code;
  logic [31:0] req_w1, req_w2;
  logic        req_has2;

  assign req_ready_o   = (state_q == S_IDLE);
  assign accept        = req_valid_i && req_ready_o;
  assign instr_valid_o = (state_q != S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign instr_o       = instr_q;
  assign instr_last_o  = last_q;
  assign err_o         = err_q;
  assign err_code_o    = code_q;

  // Sign-extension checks: upper bits must all match the sign bit
  assign fit12  = (&req_imm_i[63:11]) | ~(|req_imm_i[63:11]);
  assign fit13  = (&req_imm_i[63:12]) | ~(|req_imm_i[63:12]);
  assign fit32  = (&req_imm_i[63:31]) | ~(|req_imm_i[63:31]);
  // Rounding the upper part compensates for ADDIW sign-extending lo
  assign hi_sum = req_imm_i[31:0] + 32'h0000_0800;
  assign lo     = req_imm_i[11:0];

  // Range check and word packing for the presented request
  always_comb begin
    req_code = 2'd0;
    req_w1   = 32'd0;
    req_w2   = 32'd0;
    req_has2 = 1'b0;
    case (req_kind_i)
      K_LOAD: begin
        if (!fit12) req_code = 2'd1;
        req_w1 = {req_imm_i[11:0], req_rs1_i, req_funct3_i, req_rd_i, OP_LOAD};
      end
      K_STORE: begin
        if (!fit12) req_code = 2'd1;
        req_w1 = {req_imm_i[11:5], req_rs2_i, req_rs1_i, req_funct3_i,
                  req_imm_i[4:0], OP_STORE};
      end
      K_BRANCH: begin
        // Misalignment takes priority over out-of-range
        if (req_imm_i[0])  req_code = 2'd2;
        else if (!fit13)   req_code = 2'd1;
        req_w1 = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i,
                  req_funct3_i, req_imm_i[4:1], req_imm_i[11], OP_BRANCH};
      end
      K_LUI: begin
        if (!fit32 || (req_imm_i[11:0] != 12'd0)) req_code = 2'd1;
        req_w1 = {req_imm_i[31:12], req_rd_i, OP_LUI};
      end
      K_AUIPC: begin
        if (!fit32 || (req_imm_i[11:0] != 12'd0)) req_code = 2'd1;
        req_w1 = {req_imm_i[31:12], req_rd_i, OP_AUIPC};
      end
      K_LI: begin
        if (!fit32) begin
          req_code = 2'd1;
        end else if (fit12) begin
          req_w1 = {lo, 5'd0, 3'b000, req_rd_i, OP_ADDI};
        end else begin
          req_w1 = {hi_sum[31:12], req_rd_i, OP_LUI};
          if (lo != 12'd0) begin
            // ADDIW keeps the result sign-extended from bit 31 on RV64
            req_has2 = 1'b1;
            req_w2   = {lo, req_rd_i, 3'b000, req_rd_i, OP_ADDIW};
          end
        end
      end
      K_ADDI: begin
        if (!fit12) req_code = 2'd1;
        req_w1 = {req_imm_i[11:0], req_rs1_i, 3'b000, req_rd_i, OP_ADDI};
      end
      default: req_code = 2'd3;
    endcase
  end

  // Next-state: accept in IDLE, step through one or two output words
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    last_d  = last_q;
    word2_d = word2_q;
    has2_d  = has2_q;
    err_d   = 1'b0;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          code_d = req_code;
          if (req_code != 2'd0) begin
            err_d = 1'b1;
          end else begin
            instr_d = req_w1;
            last_d  = !req_has2;
            word2_d = req_w2;
            has2_d  = req_has2;
            state_d = S_EMIT1;
          end
        end
      end
      S_EMIT1: begin
        if (instr_ready_i) begin
          if (has2_q) begin
            instr_d = word2_q;
            last_d  = 1'b1;
            state_d = S_EMIT2;
          end else begin
            last_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_EMIT2: begin
        if (instr_ready_i) begin
          last_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      instr_q <= 32'd0;
      last_q  <= 1'b0;
      word2_q <= 32'd0;
      has2_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      word2_q <= word2_d;
      has2_q  <= has2_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

endmodule
